// File: rtl/money_ledger.sv
// Roulette balance manager: debits a round of stakes, then credits hit slots one per cycle.
// The balance saturates at MAX_MONEY. The block also keeps round and win statistics.
module money_ledger #(
  parameter int W          = 16,
  parameter int N_BETS     = 4,
  parameter int INIT_MONEY = 100,
  parameter int MAX_MONEY  = 10000,
  parameter int MULT_BASE  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [N_BETS-1:0]     bet_valid,
  input  logic [N_BETS*W-1:0]   bet_amount,
  input  logic [N_BETS-1:0]     bet_hit,
  output logic                  busy,
  output logic                  done,
  output logic                  reject,
  output logic [W-1:0]          current_money,
  output logic signed [W:0]     last_delta,
  output logic                  money_zero,
  output logic                  goal_reached,
  output logic [15:0]           round_count,
  output logic [15:0]           win_rounds
);
  localparam int IW = (N_BETS > 1) ? $clog2(N_BETS) : 1;
  localparam int KW = $clog2(N_BETS + 1);
  localparam int SW = W + $clog2(N_BETS);
  localparam int MW = $clog2(MULT_BASE + 2);
  localparam int PW = W + MW + 1;

  typedef enum logic [1:0] {IDLE, CHECK, SETTLE, DONE} state_t;

  state_t                state_q, state_d;
  logic [N_BETS-1:0]     valid_q, valid_d, hit_q, hit_d;
  logic [N_BETS*W-1:0]   amount_q, amount_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [KW-1:0]         k_q, k_d, k_now;
  logic [SW-1:0]         sum_now;
  logic [W-1:0]          money_q, money_d, start_money_q, start_money_d;
  logic                  won_q, won_d, reject_q, reject_d;
  logic signed [W:0]     last_delta_q, last_delta_d;
  logic [15:0]           round_q, round_d, win_q, win_d;
  logic [W-1:0]          slot_amt;
  logic [PW-1:0]         pay;

  function automatic logic [W-1:0] sat_money(input logic [PW-1:0] v);
    if (v > PW'(MAX_MONEY)) return W'(MAX_MONEY);
    return v[W-1:0];
  endfunction

  // A shift that runs past the top bit yields zero, which is the intended "no payout" case.
  function automatic logic [MW-1:0] slot_mult(input logic [KW-1:0] k);
    logic [MW-1:0] base;
    base = MW'(MULT_BASE);
    if (k == '0) return '0;
    return base >> (k - KW'(1));
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  always_comb begin
    k_now   = '0;
    sum_now = '0;
    for (int i = 0; i < N_BETS; i++) begin
      if (valid_q[i]) begin
        k_now   = k_now + KW'(1);
        sum_now = sum_now + SW'(amount_q[i*W +: W]);
      end
    end
  end

  always_comb begin
    slot_amt = amount_q[idx_q*W +: W];
    pay      = '0;
    if (valid_q[idx_q] && hit_q[idx_q]) pay = PW'(slot_amt) * PW'(slot_mult(k_q));
  end

  always_comb begin
    state_d       = state_q;
    valid_d       = valid_q;
    amount_d      = amount_q;
    hit_d         = hit_q;
    idx_d         = idx_q;
    k_d           = k_q;
    money_d       = money_q;
    start_money_d = start_money_q;
    won_d         = won_q;
    last_delta_d  = last_delta_q;
    round_d       = round_q;
    win_d         = win_q;
    reject_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          valid_d  = bet_valid;
          amount_d = bet_amount;
          hit_d    = bet_hit;
          state_d  = CHECK;
        end
      end
      CHECK: begin
        if (k_now == '0 || sum_now > SW'(money_q) || goal_reached) begin
          reject_d = 1'b1;
          state_d  = IDLE;
        end else begin
          money_d       = money_q - sum_now[W-1:0];
          start_money_d = money_q;
          k_d           = k_now;
          idx_d         = '0;
          won_d         = 1'b0;
          state_d       = SETTLE;
        end
      end
      SETTLE: begin
        money_d = sat_money(PW'(money_q) + pay);
        if (pay != '0) won_d = 1'b1;
        if (idx_q == IW'(N_BETS - 1)) begin
          // Statistics are committed on entry to DONE so they are valid alongside the done pulse.
          last_delta_d = $signed({1'b0, money_d}) - $signed({1'b0, start_money_q});
          round_d      = sat_inc16(round_q);
          if (won_d) win_d = sat_inc16(win_q);
          state_d      = DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      money_q      <= W'(INIT_MONEY);
      last_delta_q <= '0;
      round_q      <= '0;
      win_q        <= '0;
      reject_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      money_q      <= money_d;
      last_delta_q <= last_delta_d;
      round_q      <= round_d;
      win_q        <= win_d;
      reject_q     <= reject_d;
    end
  end

  // Captured bets and per-round scratch are only meaningful outside IDLE, so they need no reset.
  always_ff @(posedge clk) begin
    valid_q       <= valid_d;
    amount_q      <= amount_d;
    hit_q         <= hit_d;
    idx_q         <= idx_d;
    k_q           <= k_d;
    start_money_q <= start_money_d;
    won_q         <= won_d;
  end

  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign reject        = reject_q;
  assign current_money = money_q;
  assign last_delta    = last_delta_q;
  assign money_zero    = (money_q == '0);
  assign goal_reached  = (money_q >= W'(MAX_MONEY));
  assign round_count   = round_q;
  assign win_rounds    = win_q;
endmodule

// File: tb/tb_money_ledger.sv
// Directed bench for money_ledger: main instance with defaults, second instance with MAX_MONEY=110.
module tb_money_ledger;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  bet_valid = '0;
  logic [63:0] bet_amount = '0;
  logic [3:0]  bet_hit = '0;

  logic        busy, done, reject, mz, gr;
  logic [15:0] money, rc, wr;
  logic signed [16:0] delta;
  logic        s_busy, s_done, s_reject, s_mz, s_gr;
  logic [15:0] s_money, s_rc, s_wr;
  logic signed [16:0] s_delta;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  money_ledger u_dut (
    .clk(clk), .rst(rst), .start(start), .bet_valid(bet_valid), .bet_amount(bet_amount),
    .bet_hit(bet_hit), .busy(busy), .done(done), .reject(reject), .current_money(money),
    .last_delta(delta), .money_zero(mz), .goal_reached(gr), .round_count(rc), .win_rounds(wr)
  );

  money_ledger #(.MAX_MONEY(110)) u_sat (
    .clk(clk), .rst(rst), .start(start), .bet_valid(bet_valid), .bet_amount(bet_amount),
    .bet_hit(bet_hit), .busy(s_busy), .done(s_done), .reject(s_reject), .current_money(s_money),
    .last_delta(s_delta), .money_zero(s_mz), .goal_reached(s_gr), .round_count(s_rc), .win_rounds(s_wr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; start = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic set_bets(input logic [15:0] a0, a1, a2, a3, input logic [3:0] v, h);
    bet_amount = {a3, a2, a1, a0};
    bet_valid  = v;
    bet_hit    = h;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (money !== 16'd100) begin bad++; $display("FAIL reset_money got=%0d want=100", money); end
    total++; if ({busy, done, reject} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b want=000", {busy, done, reject}); end
    total++; if (rc !== 16'd0 || wr !== 16'd0) begin bad++; $display("FAIL reset_counters got=%0d/%0d want=0/0", rc, wr); end
    total++; if ({mz, gr} !== 2'b00) begin bad++; $display("FAIL reset_decodes got=%b want=00", {mz, gr}); end
    total++; if (delta !== 17'sd0) begin bad++; $display("FAIL reset_delta got=%0d want=0", delta); end
  endtask

  task automatic test_single_hit();
    do_reset();
    set_bets(16'd10, 16'd0, 16'd0, 16'd0, 4'b0001, 4'b0001);
    start = 1'b1;
    tick(); start = 1'b0;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL single_busy_t1 got=%b want=1", busy); end
    tick();
    total++; if (money !== 16'd90) begin bad++; $display("FAIL single_debit got=%0d want=90", money); end
    tick();
    total++; if (money !== 16'd170) begin bad++; $display("FAIL single_slot0 got=%0d want=170", money); end
    tick(); tick();
    total++; if (done !== 1'b0) begin bad++; $display("FAIL single_early_done got=%b want=0", done); end
    tick();
    total++; if (done !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL single_done_t6 got=%b%b want=11", done, busy); end
    total++; if (delta !== 17'sd70) begin bad++; $display("FAIL single_delta got=%0d want=70", delta); end
    total++; if (rc !== 16'd1 || wr !== 16'd1) begin bad++; $display("FAIL single_counters got=%0d/%0d want=1/1", rc, wr); end
    tick();
    total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL single_idle_t7 got=%b%b want=00", busy, done); end
  endtask

  task automatic test_two_slots();
    do_reset();
    set_bets(16'd10, 16'd20, 16'd0, 16'd0, 4'b0011, 4'b0010);
    start = 1'b1;
    tick(); start = 1'b0;
    set_bets(16'd999, 16'd999, 16'd999, 16'd999, 4'b1111, 4'b1111);
    tick();
    total++; if (money !== 16'd70) begin bad++; $display("FAIL two_debit got=%0d want=70", money); end
    tick();
    total++; if (money !== 16'd70) begin bad++; $display("FAIL two_slot0_miss got=%0d want=70", money); end
    tick();
    total++; if (money !== 16'd150) begin bad++; $display("FAIL two_slot1_hit got=%0d want=150", money); end
    tick(); tick();
    total++; if (done !== 1'b1) begin bad++; $display("FAIL two_done got=%b want=1", done); end
    total++; if (delta !== 17'sd50) begin bad++; $display("FAIL two_delta got=%0d want=50", delta); end
    total++; if (wr !== 16'd1) begin bad++; $display("FAIL two_win got=%0d want=1", wr); end
    tick();
  endtask

  task automatic test_total_loss();
    do_reset();
    set_bets(16'd25, 16'd25, 16'd25, 16'd25, 4'b1111, 4'b0000);
    start = 1'b1;
    tick(); start = 1'b0;
    tick();
    total++; if (money !== 16'd0 || mz !== 1'b1) begin bad++; $display("FAIL loss_debit got=%0d/%b want=0/1", money, mz); end
    tick(); tick(); tick(); tick();
    total++; if (done !== 1'b1) begin bad++; $display("FAIL loss_done got=%b want=1", done); end
    total++; if (delta !== -17'sd100) begin bad++; $display("FAIL loss_delta got=%0d want=-100", delta); end
    total++; if (rc !== 16'd1 || wr !== 16'd0) begin bad++; $display("FAIL loss_counters got=%0d/%0d want=1/0", rc, wr); end
    tick();
    set_bets(16'd1, 16'd0, 16'd0, 16'd0, 4'b0001, 4'b0001);
    start = 1'b1;
    tick(); start = 1'b0;
    total++; if (busy !== 1'b1 || reject !== 1'b0) begin bad++; $display("FAIL lock_t1 got=%b%b want=10", busy, reject); end
    tick();
    total++; if (reject !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL lock_reject got=%b%b want=10", reject, busy); end
    total++; if (money !== 16'd0 || rc !== 16'd1) begin bad++; $display("FAIL lock_state got=%0d/%0d want=0/1", money, rc); end
    tick();
    total++; if (reject !== 1'b0) begin bad++; $display("FAIL lock_pulse got=%b want=0", reject); end
  endtask

  task automatic test_refusals();
    int dones;
    do_reset();
    set_bets(16'd60, 16'd50, 16'd0, 16'd0, 4'b0011, 4'b0011);
    start = 1'b1;
    tick(); start = 1'b0;
    tick();
    total++; if (reject !== 1'b1 || money !== 16'd100) begin bad++; $display("FAIL over_reject got=%b/%0d want=1/100", reject, money); end
    set_bets(16'd10, 16'd0, 16'd0, 16'd0, 4'b0000, 4'b0001);
    start = 1'b1;
    tick(); start = 1'b0;
    tick();
    total++; if (reject !== 1'b1 || money !== 16'd100) begin bad++; $display("FAIL empty_reject got=%b/%0d want=1/100", reject, money); end
    set_bets(16'd10, 16'd0, 16'd0, 16'd0, 4'b0001, 4'b0000);
    start = 1'b1;
    dones = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      start = (c == 2);
      if (done) dones++;
    end
    total++; if (dones != 1) begin bad++; $display("FAIL busy_start_dones got=%0d want=1", dones); end
    total++; if (money !== 16'd90 || rc !== 16'd1) begin bad++; $display("FAIL busy_start_state got=%0d/%0d want=90/1", money, rc); end
  endtask

  task automatic test_saturation();
    do_reset();
    total++; if (s_gr !== 1'b0 || s_money !== 16'd100) begin bad++; $display("FAIL sat_reset got=%b/%0d want=0/100", s_gr, s_money); end
    set_bets(16'd20, 16'd0, 16'd0, 16'd0, 4'b0001, 4'b0001);
    start = 1'b1;
    tick(); start = 1'b0;
    tick();
    total++; if (s_money !== 16'd80) begin bad++; $display("FAIL sat_debit got=%0d want=80", s_money); end
    tick();
    total++; if (s_money !== 16'd110 || s_gr !== 1'b1) begin bad++; $display("FAIL sat_clamp got=%0d/%b want=110/1", s_money, s_gr); end
    tick(); tick(); tick();
    total++; if (s_done !== 1'b1 || s_delta !== 17'sd10) begin bad++; $display("FAIL sat_done got=%b/%0d want=1/10", s_done, s_delta); end
    tick();
    start = 1'b1;
    tick(); start = 1'b0;
    tick();
    total++; if (s_reject !== 1'b1 || s_money !== 16'd110 || s_rc !== 16'd1) begin bad++; $display("FAIL sat_goal_reject got=%b/%0d/%0d want=1/110/1", s_reject, s_money, s_rc); end
  endtask

  task automatic test_reset_mid_settle();
    int dones;
    do_reset();
    set_bets(16'd10, 16'd0, 16'd0, 16'd0, 4'b0001, 4'b0001);
    start = 1'b1;
    tick(); start = 1'b0;
    tick(); tick();
    total++; if (money !== 16'd170) begin bad++; $display("FAIL mid_pre got=%0d want=170", money); end
    rst = 1'b1;
    tick(); rst = 1'b0;
    total++; if (money !== 16'd100 || busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL mid_reset got=%0d/%b%b want=100/00", money, busy, done); end
    dones = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (done) dones++;
    end
    total++; if (dones != 0 || rc !== 16'd0) begin bad++; $display("FAIL mid_no_done got=%0d/%0d want=0/0", dones, rc); end
  endtask

  initial begin
    test_reset();
    test_single_hit();
    test_two_slots();
    test_total_loss();
    test_refusals();
    test_saturation();
    test_reset_mid_settle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
